// File: rtl/mvp_sched_pkg.sv
// Shared types for the MVP frame scheduler:
// FSM states, the output-entry layout and the coordinate saturation helper.
package mvp_sched_pkg;

   localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

   typedef enum logic [3:0] {
      IDLE,
      U_START,
      U_ARM,
      U_WAIT,
      FETCH,
      X_START,
      X_ARM,
      X_WAIT,
      PUSH,
      DONE
   } state_e;

   typedef struct packed {
      logic signed [11:0] x;
      logic signed [11:0] y;
      logic               offscreen;
      logic               last;
   } out_entry_t;

   function automatic logic signed [11:0] sat12(input logic signed [31:0] v);
      if (v > 32'sd2047)
         return 12'sh7FF;
      else if (v < -32'sd2048)
         return 12'sh800;
      else
         return v[11:0];
   endfunction

endpackage

// File: rtl/mvp_scheduler_if.sv
// Projected-vertex stream from the scheduler FIFO to the line rasterizer.
// Valid/ready handshake; head entry is popped when both are high.
interface mvp_scheduler_if;

   logic               out_valid;
   logic               out_ready;
   logic signed [11:0] out_x;
   logic signed [11:0] out_y;
   logic               out_offscreen;
   logic               out_last;

   modport master (
      output out_valid,
      output out_x,
      output out_y,
      output out_offscreen,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_x,
      input  out_y,
      input  out_offscreen,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/mvp_scheduler_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; head is shown combinationally.
// Push on full and pop on empty are dropped.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] P_ONE = 1;
   localparam logic [AW:0]   C_ONE = 1;
   localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == C_FULL);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + P_ONE;
         end
         if (do_pop)
            rd_q <= rd_q + P_ONE;
         if (do_push && !do_pop)
            cnt_q <= cnt_q + C_ONE;
         else if (do_pop && !do_push)
            cnt_q <= cnt_q - C_ONE;
      end
   end

endmodule

// File: rtl/mvp_scheduler.sv
// Frame sequencer for the MVP engine: one pose update per frame, then every
// ROM vertex is transformed and pushed as a saturated screen point.
module mvp_scheduler
   import mvp_sched_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int MEM_LAT    = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int SCR_W      = 640,
   parameter int SCR_H      = 480
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              frame_start,
   input  logic [ADDR_W:0]   num_verts,
   input  logic [31:0]       roll,
   input  logic [31:0]       pitch,
   input  logic [31:0]       yaw,
   input  logic [31:0]       speed,
   input  logic [31:0]       cam_x,
   input  logic [31:0]       cam_y,
   input  logic [31:0]       cam_z,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_overrun,
   output logic              mvp_start,
   output logic              mvp_update,
   output logic [31:0]       mvp_roll,
   output logic [31:0]       mvp_pitch,
   output logic [31:0]       mvp_yaw,
   output logic [31:0]       mvp_speed,
   output logic [31:0]       mvp_x,
   output logic [31:0]       mvp_y,
   output logic [31:0]       mvp_z,
   input  logic              mvp_done,
   input  logic [31:0]       mvp_vx,
   input  logic [31:0]       mvp_vy,
   input  logic [31:0]       mvp_vz,
   input  logic [31:0]       mvp_ox,
   input  logic [31:0]       mvp_oy,
   output logic [31:0]       vel_x,
   output logic [31:0]       vel_y,
   output logic [31:0]       vel_z,
   output logic [ADDR_W-1:0] vert_addr,
   input  logic [95:0]       vert_data,
   mvp_scheduler_if.master   out_if
);

   localparam logic [ADDR_W:0] I_ONE = 1;
   localparam logic [2:0]      LAT   = 3'(MEM_LAT);
   localparam logic [2:0]      L_ONE = 3'd1;
   localparam logic [31:0]     XLIM  = 32'(SCR_W);
   localparam logic [31:0]     YLIM  = 32'(SCR_H);

   state_e          state_q, state_d;
   logic [ADDR_W:0] nv_q, nv_d, idx_q, idx_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [31:0]     roll_q, roll_d, pitch_q, pitch_d;
   logic [31:0]     yaw_q, yaw_d, speed_q, speed_d;
   logic [31:0]     mx_q, mx_d, my_q, my_d, mz_q, mz_d;
   logic [31:0]     vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
   logic            upd_q, upd_d, ovr_q, ovr_d;
   logic            push, full, empty, last;
   out_entry_t      ent, head;

   assign last = (idx_q == nv_q - I_ONE);

   // Unsigned compare folds the negative-coordinate case into the range test.
   assign ent.x         = sat12(mvp_ox);
   assign ent.y         = sat12(mvp_oy);
   assign ent.offscreen = (mvp_ox >= XLIM) | (mvp_oy >= YLIM);
   assign ent.last      = last;

   always_comb begin
      state_d = state_q;
      nv_d    = nv_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      roll_d  = roll_q;
      pitch_d = pitch_q;
      yaw_d   = yaw_q;
      speed_d = speed_q;
      mx_d    = mx_q;
      my_d    = my_q;
      mz_d    = mz_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vz_d    = vz_q;
      upd_d   = upd_q;
      ovr_d   = frame_start & (state_q != IDLE);
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               nv_d    = num_verts;
               idx_d   = '0;
               roll_d  = roll;
               pitch_d = pitch;
               yaw_d   = yaw;
               speed_d = speed;
               mx_d    = cam_x;
               my_d    = cam_y;
               mz_d    = cam_z;
               upd_d   = 1'b1;
               state_d = U_START;
            end
         end
         U_START: state_d = U_ARM;
         U_ARM:   state_d = U_WAIT;
         U_WAIT: begin
            if (mvp_done) begin
               vx_d = mvp_vx;
               vy_d = mvp_vy;
               vz_d = mvp_vz;
               cnt_d = '0;
               state_d = (nv_q == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (cnt_q == LAT) begin
               mx_d    = vert_data[95:64];
               my_d    = vert_data[63:32];
               mz_d    = vert_data[31:0];
               upd_d   = 1'b0;
               state_d = X_START;
            end else begin
               cnt_d = cnt_q + L_ONE;
            end
         end
         X_START: state_d = X_ARM;
         X_ARM:   state_d = X_WAIT;
         X_WAIT: begin
            if (mvp_done)
               state_d = PUSH;
         end
         PUSH: begin
            if (!full) begin
               push = 1'b1;
               if (last) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + I_ONE;
                  cnt_d   = '0;
                  state_d = FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         nv_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         roll_q  <= '0;
         pitch_q <= '0;
         yaw_q   <= '0;
         speed_q <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         mz_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vz_q    <= '0;
         upd_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nv_q    <= nv_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         roll_q  <= roll_d;
         pitch_q <= pitch_d;
         yaw_q   <= yaw_d;
         speed_q <= speed_d;
         mx_q    <= mx_d;
         my_q    <= my_d;
         mz_q    <= mz_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vz_q    <= vz_d;
         upd_q   <= upd_d;
         ovr_q   <= ovr_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(out_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .push_i  (push),
      .din_i   (ent),
      .pop_i   (out_if.out_valid & out_if.out_ready),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign busy          = (state_q != IDLE);
   assign frame_done    = (state_q == DONE);
   assign frame_overrun = ovr_q;
   assign mvp_start     = (state_q == U_START) | (state_q == X_START);
   assign mvp_update    = upd_q;
   assign mvp_roll      = roll_q;
   assign mvp_pitch     = pitch_q;
   assign mvp_yaw       = yaw_q;
   assign mvp_speed     = speed_q;
   assign mvp_x         = mx_q;
   assign mvp_y         = my_q;
   assign mvp_z         = mz_q;
   assign vel_x         = vx_q;
   assign vel_y         = vy_q;
   assign vel_z         = vz_q;
   assign vert_addr     = idx_q[ADDR_W-1:0];

   assign out_if.out_valid     = ~empty;
   assign out_if.out_x         = head.x;
   assign out_if.out_y         = head.y;
   assign out_if.out_offscreen = head.offscreen;
   assign out_if.out_last      = head.last;

endmodule

// File: tb/tb_mvp_scheduler.sv
// Directed bench for mvp_scheduler with a behavioural engine and vertex ROM.
// Screen entries and engine handshakes are logged on the falling edge.
module tb_mvp_scheduler;

   logic        clock = 1'b0;
   logic        resetn;
   logic        frame_start;
   logic [10:0] num_verts;
   logic [31:0] roll, pitch, yaw, speed, cam_x, cam_y, cam_z;
   logic        busy, frame_done, frame_overrun, mvp_start, mvp_update;
   logic [31:0] mvp_roll, mvp_pitch, mvp_yaw, mvp_speed;
   logic [31:0] mvp_x, mvp_y, mvp_z;
   logic        mvp_done;
   logic [31:0] mvp_vx, mvp_vy, mvp_vz, mvp_ox, mvp_oy;
   logic [31:0] vel_x, vel_y, vel_z;
   logic [9:0]  vert_addr;
   logic [95:0] vert_data;

   mvp_scheduler_if ifc ();

   mvp_scheduler dut (
      .clock(clock), .resetn(resetn), .frame_start(frame_start),
      .num_verts(num_verts), .roll(roll), .pitch(pitch), .yaw(yaw),
      .speed(speed), .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
      .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun),
      .mvp_start(mvp_start), .mvp_update(mvp_update),
      .mvp_roll(mvp_roll), .mvp_pitch(mvp_pitch), .mvp_yaw(mvp_yaw),
      .mvp_speed(mvp_speed), .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z),
      .mvp_done(mvp_done), .mvp_vx(mvp_vx), .mvp_vy(mvp_vy),
      .mvp_vz(mvp_vz), .mvp_ox(mvp_ox), .mvp_oy(mvp_oy),
      .vel_x(vel_x), .vel_y(vel_y), .vel_z(vel_z),
      .vert_addr(vert_addr), .vert_data(vert_data), .out_if(ifc.master)
   );

   always #5 clock = ~clock;

   int nvec = 0;
   int nerr = 0;

   // Engine model: fixed 3-cycle latency, done drops right after start.
   logic [31:0] ox_tab [16];
   logic [31:0] oy_tab [16];
   int          eng_cnt;
   logic        eng_upd;
   logic [31:0] ex, ey, ez;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mvp_done <= 1'b1;
         eng_cnt  <= 0;
         eng_upd  <= 1'b0;
         ex <= '0; ey <= '0; ez <= '0;
         mvp_vx <= '0; mvp_vy <= '0; mvp_vz <= '0;
         mvp_ox <= '0; mvp_oy <= '0;
      end else if (mvp_start) begin
         mvp_done <= 1'b0;
         eng_cnt  <= 3;
         eng_upd  <= mvp_update;
         ex <= mvp_x; ey <= mvp_y; ez <= mvp_z;
      end else if (eng_cnt == 1) begin
         eng_cnt  <= 0;
         mvp_done <= 1'b1;
         if (eng_upd) begin
            mvp_vx <= ex ^ 32'hA5A5_0000;
            mvp_vy <= ey + 32'd1;
            mvp_vz <= ~ez;
         end else begin
            mvp_ox <= ox_tab[ex[3:0]];
            mvp_oy <= oy_tab[ex[3:0]];
         end
      end else if (eng_cnt > 1) begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   // Vertex ROM with two cycles of read latency: vertex i = {i, i+100, i+200}.
   logic [95:0] rom_p0, rom_p1;
   always @(posedge clock) begin
      rom_p0 <= {32'(vert_addr), 32'(vert_addr) + 32'd100,
                 32'(vert_addr) + 32'd200};
      rom_p1 <= rom_p0;
   end
   assign vert_data = rom_p1;

   int          cyc = 0;
   int          st_cnt, upd_starts, fd_cnt, ov_cnt, fd_cyc, rise_cyc;
   logic        done_prev = 1'b1;
   logic [9:0]  addr_q [$];
   logic [31:0] mx_q [$];
   logic [25:0] ent_q [$];

   always @(negedge clock) begin
      cyc++;
      if (mvp_start) begin
         st_cnt++;
         if (mvp_update)
            upd_starts++;
         else begin
            addr_q.push_back(vert_addr);
            mx_q.push_back(mvp_x);
         end
      end
      if (frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if (frame_overrun)
         ov_cnt++;
      if (mvp_done && !done_prev)
         rise_cyc = cyc;
      done_prev = mvp_done;
      if (ifc.out_valid && ifc.out_ready)
         ent_q.push_back({ifc.out_x, ifc.out_y, ifc.out_offscreen, ifc.out_last});
   end

   function automatic logic [25:0] mk(input int x, input int y,
                                      input logic off, input logic lst);
      logic [31:0] xv, yv;
      xv = x;
      yv = y;
      return {xv[11:0], yv[11:0], off, lst};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic clear_logs();
      st_cnt = 0; upd_starts = 0; fd_cnt = 0; ov_cnt = 0;
      fd_cyc = 0; rise_cyc = 0;
      addr_q.delete(); mx_q.delete(); ent_q.delete();
   endtask

   task automatic start_frame(input int nv, input logic [31:0] r);
      frame_start = 1'b1;
      num_verts   = 11'(nv);
      roll        = r;
      step(1);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      int f0;
      f0 = fd_cnt;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step(1);
         if (fd_cnt != f0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nvec++;
      if ({busy, frame_done, frame_overrun, mvp_start, mvp_update} !== 5'b0) begin
         nerr++;
         $display("FAIL reset_flags: got %b want 00000",
                  {busy, frame_done, frame_overrun, mvp_start, mvp_update});
      end
      nvec++;
      if ({mvp_roll, mvp_x, vel_x, vel_z} !== 128'b0) begin
         nerr++;
         $display("FAIL reset_regs: roll=%h x=%h vx=%h vz=%h want 0",
                  mvp_roll, mvp_x, vel_x, vel_z);
      end
      nvec++;
      if ({vert_addr, ifc.out_valid, ifc.out_x, ifc.out_last} !== 24'b0) begin
         nerr++;
         $display("FAIL reset_out: addr=%0d v=%b x=%h want 0",
                  vert_addr, ifc.out_valid, ifc.out_x);
      end
   endtask

   task automatic test_zero_verts();
      bit ok;
      clear_logs();
      cam_x = 32'h3F80_0000; cam_y = 32'h4000_0000; cam_z = 32'h4040_0000;
      ifc.out_ready = 1'b1;
      start_frame(0, 32'h1234_5678);
      wait_done(100, ok);
      step(3);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL zero_done: frame_done not seen in 100 cycles");
      end
      nvec++;
      if (st_cnt !== 1 || upd_starts !== 1) begin
         nerr++;
         $display("FAIL zero_starts: got %0d/%0d want 1/1", st_cnt, upd_starts);
      end
      nvec++;
      if ({vel_x, vel_y, vel_z} !== {32'h9A25_0000, 32'h4000_0001, 32'hBFBF_FFFF}) begin
         nerr++;
         $display("FAIL zero_vel: got %h %h %h want 9a250000 40000001 bfbfffff",
                  vel_x, vel_y, vel_z);
      end
      nvec++;
      if (fd_cyc - rise_cyc !== 1) begin
         nerr++;
         $display("FAIL zero_latency: got %0d want 1", fd_cyc - rise_cyc);
      end
      nvec++;
      if (ent_q.size() !== 0 || ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL zero_empty: entries=%0d valid=%b busy=%b want 0 0 0",
                  ent_q.size(), ifc.out_valid, busy);
      end
   endtask

   task automatic test_three_verts();
      bit ok;
      logic [25:0] exp [3];
      clear_logs();
      ox_tab[0] = 100;  oy_tab[0] = 50;
      ox_tab[1] = 700;  oy_tab[1] = 50;
      ox_tab[2] = -5;   oy_tab[2] = 479;
      exp[0] = mk(100, 50, 1'b0, 1'b0);
      exp[1] = mk(700, 50, 1'b1, 1'b0);
      exp[2] = mk(-5, 479, 1'b1, 1'b1);
      ifc.out_ready = 1'b1;
      start_frame(3, 32'h0);
      wait_done(200, ok);
      step(3);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL three_done: frame_done not seen in 200 cycles");
      end
      nvec++;
      if (st_cnt !== 4) begin
         nerr++;
         $display("FAIL three_starts: got %0d want 4", st_cnt);
      end
      nvec++;
      if (addr_q.size() !== 3 || ent_q.size() !== 3) begin
         nerr++;
         $display("FAIL three_count: addrs=%0d entries=%0d want 3 3",
                  addr_q.size(), ent_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            nvec++;
            if (addr_q[i] !== 10'(i) || mx_q[i] !== 32'(i)) begin
               nerr++;
               $display("FAIL three_addr%0d: addr=%0d x=%0d want %0d",
                        i, addr_q[i], mx_q[i], i);
            end
            nvec++;
            if (ent_q[i] !== exp[i]) begin
               nerr++;
               $display("FAIL three_entry%0d: got %h want %h", i, ent_q[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [25:0] exp [4];
      clear_logs();
      ox_tab[0] = 32'h0000_1000; oy_tab[0] = 10;
      ox_tab[1] = -70000;        oy_tab[1] = 10;
      ox_tab[2] = 639;           oy_tab[2] = 479;
      ox_tab[3] = 0;             oy_tab[3] = 480;
      exp[0] = mk(2047, 10, 1'b1, 1'b0);
      exp[1] = mk(-2048, 10, 1'b1, 1'b0);
      exp[2] = mk(639, 479, 1'b0, 1'b0);
      exp[3] = mk(0, 480, 1'b1, 1'b1);
      ifc.out_ready = 1'b1;
      start_frame(4, 32'h0);
      wait_done(300, ok);
      step(3);
      nvec++;
      if (!ok || ent_q.size() !== 4) begin
         nerr++;
         $display("FAIL sat_count: done=%0d entries=%0d want 1 4", ok, ent_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            nvec++;
            if (ent_q[i] !== exp[i]) begin
               nerr++;
               $display("FAIL sat_entry%0d: got %h want %h", i, ent_q[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_logs();
      for (int i = 0; i < 12; i++) begin
         ox_tab[i] = 32'(i * 10 + 5);
         oy_tab[i] = 32'(i);
      end
      ifc.out_ready = 1'b0;
      start_frame(12, 32'h0);
      step(300);
      nvec++;
      if (busy !== 1'b1 || vert_addr !== 10'd8 || st_cnt !== 10) begin
         nerr++;
         $display("FAIL bp_stall: busy=%b addr=%0d starts=%0d want 1 8 10",
                  busy, vert_addr, st_cnt);
      end
      nvec++;
      if (ifc.out_valid !== 1'b1 || ifc.out_x !== 12'sd5 || ent_q.size() !== 0) begin
         nerr++;
         $display("FAIL bp_head: valid=%b x=%0d popped=%0d want 1 5 0",
                  ifc.out_valid, ifc.out_x, ent_q.size());
      end
      ifc.out_ready = 1'b1;
      wait_done(400, ok);
      step(4);
      nvec++;
      if (!ok || ent_q.size() !== 12) begin
         nerr++;
         $display("FAIL bp_drain: done=%0d entries=%0d want 1 12", ok, ent_q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            nvec++;
            if (ent_q[i] !== mk(i * 10 + 5, i, 1'b0, i == 11)) begin
               nerr++;
               $display("FAIL bp_entry%0d: got %h want %h",
                        i, ent_q[i], mk(i * 10 + 5, i, 1'b0, i == 11));
            end
         end
      end
   endtask

   task automatic test_overrun();
      bit ok;
      clear_logs();
      ox_tab[0] = 20; oy_tab[0] = 30;
      ifc.out_ready = 1'b1;
      start_frame(1, 32'h1111_1111);
      step(3);
      start_frame(1, 32'h2222_2222);
      step(1);
      nvec++;
      if (ov_cnt !== 1 || mvp_roll !== 32'h1111_1111) begin
         nerr++;
         $display("FAIL ovr_pulse: pulses=%0d roll=%h want 1 11111111",
                  ov_cnt, mvp_roll);
      end
      wait_done(200, ok);
      step(3);
      nvec++;
      if (!ok || fd_cnt !== 1 || ent_q.size() !== 1 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL ovr_frame: done=%0d frames=%0d entries=%0d busy=%b want 1 1 1 0",
                  ok, fd_cnt, ent_q.size(), busy);
      end else begin
         nvec++;
         if (ent_q[0] !== mk(20, 30, 1'b0, 1'b1)) begin
            nerr++;
            $display("FAIL ovr_entry: got %h want %h", ent_q[0], mk(20, 30, 1'b0, 1'b1));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int n;
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         ox_tab[i] = 32'(40 + i);
         oy_tab[i] = 60;
      end
      ifc.out_ready = 1'b0;
      start_frame(3, 32'h0);
      n = 0;
      while (addr_q.size() < 2 && n < 200) begin
         step(1);
         n++;
      end
      step(1);
      nvec++;
      if (addr_q.size() !== 2 || ifc.out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL mid_setup: xstarts=%0d valid=%b want 2 1",
                  addr_q.size(), ifc.out_valid);
      end
      resetn = 1'b0;
      #1;
      nvec++;
      if (busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL mid_reset: busy=%b valid=%b want 0 0", busy, ifc.out_valid);
      end
      step(2);
      resetn = 1'b1;
      step(10);
      nvec++;
      if (fd_cnt !== 0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL mid_nodone: frames=%0d busy=%b want 0 0", fd_cnt, busy);
      end
      clear_logs();
      ox_tab[0] = 100; oy_tab[0] = 50;
      ifc.out_ready = 1'b1;
      start_frame(1, 32'h0);
      wait_done(200, ok);
      step(3);
      nvec++;
      if (!ok || ent_q.size() !== 1) begin
         nerr++;
         $display("FAIL mid_rerun: done=%0d entries=%0d want 1 1", ok, ent_q.size());
      end else begin
         nvec++;
         if (ent_q[0] !== mk(100, 50, 1'b0, 1'b1)) begin
            nerr++;
            $display("FAIL mid_entry: got %h want %h", ent_q[0], mk(100, 50, 1'b0, 1'b1));
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      frame_start = 1'b0;
      num_verts = '0;
      roll = '0; pitch = 32'h3F00_0000; yaw = 32'h3E80_0000; speed = 32'h4120_0000;
      cam_x = '0; cam_y = '0; cam_z = '0;
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ox_tab[i] = '0;
         oy_tab[i] = '0;
      end
      step(3);
      resetn = 1'b1;
      step(2);
      test_reset();
      test_zero_verts();
      test_three_verts();
      test_saturation();
      test_backpressure();
      test_overrun();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
